ysyx_22051013_imem_resp: RTL and testbench

- Instruction-memory responder on the fetch interface: the CPU side drives a PC, this block returns the 32-bit instruction word.
- Adds a valid/ready request/response handshake with programmable access latency and an error flag for bad fetch addresses.
- Contains a program-load write port so testbench or boot logic can fill the memory.
- Sits between the core's fetch stage and the simulation top; replaces the zero-latency combinational fetch.

---
 rtl/ysyx_22051013_imem_resp.sv | 116 +++++++++++
 tb/tb_ysyx_22051013_imem_resp.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22051013_imem_resp.sv
// Instruction-memory responder for the core's fetch stage.
// Takes a 64-bit fetch PC on a valid/ready request channel and returns the
// 32-bit instruction word LATENCY cycles later on a valid/ready response
// channel. Misaligned or out-of-range fetches return NOP_INST with rsp_err set.
// A separate load port fills the memory independently of the handshake.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake, req_pc sampled at acceptance
//   rsp_valid/rsp_ready response handshake, rsp_inst/rsp_err payload
//   ld_en/ld_addr/ld_data program-load write port (word indexed)
module ysyx_22051013_imem_resp #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [63:0]       req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_inst,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data
);

    localparam int unsigned       DEPTH      = 1 << ADDR_W;
    // First byte address past the end of memory; compared on the full 64 bits.
    localparam logic [63:0]       LIMIT_ADDR = BASE_ADDR + (64'd4 << ADDR_W);
    localparam logic [ADDR_W-1:0] BASE_IDX   = BASE_ADDR[ADDR_W+1:2];
    localparam logic [3:0]        LAST_CNT   = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [31:0]       r_inst;
    logic              r_err;
    logic [31:0]       r_mem [DEPTH];

    logic              w_accept;
    logic              w_err;
    logic [ADDR_W-1:0] w_idx;

    assign w_accept = (r_state == StIdle) && req_valid;
    assign w_err    = (req_pc[1:0] != 2'b00) || (req_pc < BASE_ADDR) || (req_pc >= LIMIT_ADDR);
    // Subtracting only the index bits equals ((pc - base) >> 2) truncated,
    // since the low two bits cannot borrow into the index when both are aligned;
    // misaligned PCs are flagged as errors and their index is never used.
    assign w_idx    = req_pc[ADDR_W+1:2] - BASE_IDX;

    assign rsp_inst = r_inst;
    assign rsp_err  = r_err;

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        unique case (r_state)
            StIdle: begin
                req_ready = !rst;
                if (req_valid) begin
                    w_state_nxt = StWait;
                end
            end
            StWait: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = StResp;
                end
            end
            StResp: begin
                rsp_valid = !rst;
                if (rsp_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_inst  <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Counts WAIT cycles; cleared everywhere else so each request starts at 0.
            r_cnt   <= (r_state == StWait) ? r_cnt + 4'd1 : 4'd0;
            if (w_accept) begin
                // Read happens before this edge's load write commits (read-before-write).
                r_inst <= w_err ? NOP_INST : r_mem[w_idx];
                r_err  <= w_err;
            end
        end
    end

    // Memory is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (ld_en && !rst) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

endmodule

// File: tb/tb_ysyx_22051013_imem_resp.sv
// Self-checking bench for ysyx_22051013_imem_resp. Three instances share the
// clock, reset, PC and load bus: index 0 uses LATENCY=2, index 1 LATENCY=1,
// index 2 LATENCY=15. Expected data comes from a word-array model of memory.
module tb_ysyx_22051013_imem_resp;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] SPAN = 64'd16384;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [63:0] req_pc;
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_ready;
    logic [31:0] rsp_inst [3];
    logic [2:0]  rsp_err;
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [31:0] ld_data;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model [4096];
    int          loaded [$];

    always #5 clk = ~clk;

    ysyx_22051013_imem_resp #(.LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_pc(req_pc),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_inst(rsp_inst[0]),
        .rsp_err(rsp_err[0]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    ysyx_22051013_imem_resp #(.LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_pc(req_pc),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_inst(rsp_inst[1]),
        .rsp_err(rsp_err[1]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    ysyx_22051013_imem_resp #(.LATENCY(15)) dut_l15 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_pc(req_pc),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_inst(rsp_inst[2]),
        .rsp_err(rsp_err[2]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    function automatic int lat_of(input int k);
        if (k == 0) return 2;
        if (k == 1) return 1;
        return 15;
    endfunction

    // {err, inst} as the responder should return it for this PC.
    function automatic logic [32:0] ref_fetch(input logic [63:0] pc);
        logic [1:0] low;
        low = pc[1:0];
        if (low != 2'b00 || pc < BASE || pc >= BASE + SPAN) return {1'b1, 32'h0000_0013};
        return {1'b0, model[int'((pc - BASE) >> 2)]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic load(input int a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = 12'(a);
        ld_data = d;
        @(negedge clk);
        ld_en    = 1'b0;
        model[a] = d;
    endtask

    // One full transaction on instance k. ld_at: -1 no write, 0 write in the
    // acceptance cycle, 1 write in the first WAIT cycle.
    task automatic fetch(input int k, input logic [63:0] pc, input int ld_at, input int ld_a,
                         input logic [31:0] ld_d, input string tag);
        logic [32:0] exp;
        int          n;
        exp = ref_fetch(pc);
        check({tag, ".req_ready"}, 64'(req_ready[k]), 64'd1);
        req_valid[k] = 1'b1;
        rsp_ready[k] = 1'b1;
        req_pc       = pc;
        if (ld_at == 0) begin
            ld_en = 1'b1; ld_addr = 12'(ld_a); ld_data = ld_d;
        end
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_pc       = {$urandom, $urandom};
        if (ld_at == 0) begin
            ld_en = 1'b0; model[ld_a] = ld_d;
        end
        n = 0;
        while (!rsp_valid[k] && n < 40) begin
            if (ld_at == 1 && n == 0) begin
                ld_en = 1'b1; ld_addr = 12'(ld_a); ld_data = ld_d;
            end
            @(negedge clk);
            n++;
            if (ld_at == 1 && n == 1) begin
                ld_en = 1'b0; model[ld_a] = ld_d;
            end
        end
        check({tag, ".latency"}, 64'(n), 64'(lat_of(k)));
        check({tag, ".inst"}, 64'(rsp_inst[k]), 64'(exp[31:0]));
        check({tag, ".err"}, 64'(rsp_err[k]), 64'(exp[32]));
        @(negedge clk);
        check({tag, ".valid_after"}, 64'(rsp_valid[k]), 64'd0);
        check({tag, ".ready_after"}, 64'(req_ready[k]), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        int          stale;
        int          a;
        logic [63:0] pc;
        logic [32:0] exp;

        rst       = 1'b1;
        req_valid = 3'b000;
        rsp_ready = 3'b000;
        req_pc    = 64'd0;
        ld_en     = 1'b0;
        ld_addr   = 12'd0;
        ld_data   = 32'd0;
        repeat (2) @(negedge clk);
        check("rst.req_ready", 64'(req_ready[0]), 64'd0);
        check("rst.rsp_valid", 64'(rsp_valid[0]), 64'd0);
        check("rst.rsp_inst", 64'(rsp_inst[0]), 64'd0);
        check("rst.rsp_err", 64'(rsp_err[0]), 64'd0);
        rst = 1'b0;
        #1;
        check("rst.ready_after", 64'(req_ready[0]), 64'd1);
        @(negedge clk);

        // Basic fetches.
        load(0, 32'h0000_0093);
        load(1, 32'h0010_0113);
        load(3, 32'h1111_1111);
        load(4095, 32'hA5A5_0FF0);
        fetch(0, BASE, -1, 0, 0, "basic0");
        fetch(0, BASE + 64'd4, -1, 0, 0, "basic1");

        // Backpressure.
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_pc       = BASE + 64'd4;
        @(negedge clk);
        req_valid[0] = 1'b0;
        n = 0;
        while (!rsp_valid[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp.latency", 64'(n), 64'd2);
        for (int i = 0; i < 5; i++) begin
            check("bp.valid", 64'(rsp_valid[0]), 64'd1);
            check("bp.inst", 64'(rsp_inst[0]), 64'h0010_0113);
            check("bp.req_ready", 64'(req_ready[0]), 64'd0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("bp.valid_after", 64'(rsp_valid[0]), 64'd0);
        check("bp.ready_after", 64'(req_ready[0]), 64'd1);

        // Error and boundary addresses.
        fetch(0, BASE + 64'd2, -1, 0, 0, "err.misalign");
        fetch(0, 64'h0000_0000_7FFF_FFFC, -1, 0, 0, "err.below");
        fetch(0, 64'h0000_0000_8000_4000, -1, 0, 0, "err.above");
        fetch(0, 64'hFFFF_FFFF_8000_0000, -1, 0, 0, "err.high64");
        fetch(0, 64'h0000_0000_8000_3FFC, -1, 0, 0, "edge.last");

        // Load collisions.
        fetch(0, BASE + 64'd12, 0, 3, 32'hDEAD_BEEF, "coll.accept");
        fetch(0, BASE + 64'd12, -1, 0, 0, "coll.readback");
        fetch(0, BASE + 64'd12, 1, 3, 32'hCAFE_F00D, "coll.wait");
        fetch(0, BASE + 64'd12, -1, 0, 0, "coll.readback2");

        // Reset during WAIT.
        req_valid[0] = 1'b1;
        req_pc       = BASE + 64'd4;
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        check("rstw.valid", 64'(rsp_valid[0]), 64'd0);
        check("rstw.ready_in_rst", 64'(req_ready[0]), 64'd0);
        rst = 1'b0;
        #1;
        check("rstw.ready", 64'(req_ready[0]), 64'd1);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid[0]) stale++;
        end
        check("rstw.no_stale", 64'(stale), 64'd0);
        fetch(0, BASE, -1, 0, 0, "rstw.word0");
        fetch(0, BASE + 64'd4, -1, 0, 0, "rstw.word1");

        // Random loads, then random fetches on the LATENCY=1 and LATENCY=15 builds.
        loaded.push_back(0);
        loaded.push_back(1);
        loaded.push_back(3);
        loaded.push_back(4095);
        for (int i = 0; i < 16; i++) begin
            a = $urandom_range(4095);
            load(a, $urandom);
            loaded.push_back(a);
        end
        for (int k = 1; k < 3; k++) begin
            for (int i = 0; i < 20; i++) begin
                a  = loaded[$urandom_range(loaded.size() - 1)];
                pc = BASE + 64'(a) * 64'd4;
                fetch(k, pc, -1, 0, 0, (k == 1) ? "rnd.l1" : "rnd.l15");
            end
        end

        // Mixed random PCs, some misaligned or out of range, on LATENCY=2.
        for (int i = 0; i < 12; i++) begin
            a  = loaded[$urandom_range(loaded.size() - 1)];
            pc = BASE + 64'(a) * 64'd4 + 64'($urandom_range(3));
            if ($urandom_range(3) == 0) pc = pc + SPAN;
            exp = ref_fetch(pc);
            fetch(0, pc, -1, 0, 0, exp[32] ? "rnd.mix_err" : "rnd.mix_ok");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
